// File: rtl/cmd_sender_pkg.sv
// Shared types and constants for the 24-bit UART command transmitter.
package cmd_sender_pkg;

    localparam int unsigned BITS_PER_FRAME = 10;
    localparam int unsigned BYTES_PER_CMD  = 3;

    typedef enum logic [1:0] {
        IDLE,
        BYTE_HI,
        BYTE_MID,
        BYTE_LO
    } cmd_state_e;

    typedef enum logic {
        TX_IDLE,
        TX_SHIFT
    } tx_state_e;

    // Byte idx of a command word, idx 0 being the most significant byte.
    function automatic logic [7:0] cmd_byte(input logic [23:0] word, input logic [1:0] idx);
        return word[(int'(BYTES_PER_CMD) - 1 - int'(idx)) * 8 +: 8];
    endfunction

endpackage

// File: rtl/cmd_sender_uart_tx.sv
// 8N1 byte serializer: loads {stop, data, start} on trmt and shifts it out LSB first.
module uart_tx
    import cmd_sender_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done
);

    localparam int unsigned CW = $clog2(BAUD_DIV);

    tx_state_e      r_state;
    logic [CW-1:0]  r_baud;
    logic [3:0]     r_bit;
    logic [9:0]     r_shift;
    logic           w_wrap;

    assign w_wrap  = (r_state == TX_SHIFT) && (r_baud == CW'(BAUD_DIV - 1));
    // Combinational so the next byte can be loaded with only one idle clock between frames.
    assign tx_done = w_wrap && (r_bit == 4'(BITS_PER_FRAME - 1));
    assign TX      = r_shift[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= TX_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '1;
        end else if (trmt) begin
            r_state <= TX_SHIFT;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= {1'b1, tx_data, 1'b0};
        end else if (r_state == TX_SHIFT) begin
            if (w_wrap) begin
                r_baud  <= '0;
                r_shift <= {1'b1, r_shift[9:1]};
                if (tx_done) begin
                    r_state <= TX_IDLE;
                    r_bit   <= '0;
                end else begin
                    r_bit <= r_bit + 4'd1;
                end
            end else begin
                r_baud <= r_baud + CW'(1);
            end
        end
    end

endmodule

// File: rtl/cmd_sender.sv
// Sends a 24-bit command as three 8N1 frames, high byte first, with busy and sticky sent flags.
module cmd_sender
    import cmd_sender_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] cmd,
    input  logic        snd_cmd,
    output logic        TX,
    output logic        busy,
    output logic        cmd_snt
);

    cmd_state_e  r_state;
    logic [23:0] r_shadow;
    logic [7:0]  r_tx_data;
    logic        r_trmt;
    logic        r_busy;
    logic        r_cmd_snt;
    logic        w_tx_done;
    logic        w_accept;

    // A new command may also be taken on the very edge the last stop bit ends.
    assign w_accept = snd_cmd && ((r_state == IDLE) || ((r_state == BYTE_LO) && w_tx_done));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shadow  <= '0;
            r_tx_data <= '0;
            r_trmt    <= 1'b0;
            r_busy    <= 1'b0;
            r_cmd_snt <= 1'b0;
        end else begin
            r_trmt <= 1'b0;
            if (w_accept) begin
                r_state   <= BYTE_HI;
                r_shadow  <= cmd;
                r_tx_data <= cmd_byte(cmd, 2'd0);
                r_trmt    <= 1'b1;
                r_busy    <= 1'b1;
                r_cmd_snt <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: ;
                    BYTE_HI: if (w_tx_done) begin
                        r_state   <= BYTE_MID;
                        r_tx_data <= cmd_byte(r_shadow, 2'd1);
                        r_trmt    <= 1'b1;
                    end
                    BYTE_MID: if (w_tx_done) begin
                        r_state   <= BYTE_LO;
                        r_tx_data <= cmd_byte(r_shadow, 2'd2);
                        r_trmt    <= 1'b1;
                    end
                    BYTE_LO: if (w_tx_done) begin
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_cmd_snt <= 1'b1;
                    end
                endcase
            end
        end
    end

    uart_tx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_uart_tx (
        .clk    (clk),
        .rst    (rst),
        .trmt   (r_trmt),
        .tx_data(r_tx_data),
        .TX     (TX),
        .tx_done(w_tx_done)
    );

    assign busy    = r_busy;
    assign cmd_snt = r_cmd_snt;

endmodule
